// File: rtl/led_blink_multi.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PULSE modes with programmable period.
// Optional global PWM dimmer compiled in with `define LED_BLINK_DIM_EN.
module led_blink_multi #(
    parameter int NUM_LEDS       = 4,
    parameter int CNT_WIDTH      = 24,
    parameter int DEFAULT_PERIOD = 1250000
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic                 i_Wr_En,
    input  logic [3:0]           i_Wr_Addr,
    input  logic [1:0]           i_Wr_Mode,
    input  logic [CNT_WIDTH-1:0] i_Wr_Period,
    input  logic                 i_Sync,
`ifdef LED_BLINK_DIM_EN
    input  logic [3:0]           i_Dim,
`endif
    output logic [NUM_LEDS-1:0]  o_LED,
    output logic [NUM_LEDS-1:0]  o_Done
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PULSE = 2'd3
    } mode_e;

    mode_e                mode_q    [NUM_LEDS];
    mode_e                mode_d    [NUM_LEDS];
    logic [CNT_WIDTH-1:0] period_q  [NUM_LEDS];
    logic [CNT_WIDTH-1:0] period_d  [NUM_LEDS];
    logic [CNT_WIDTH-1:0] counter_q [NUM_LEDS];
    logic [CNT_WIDTH-1:0] counter_d [NUM_LEDS];
    logic [NUM_LEDS-1:0]  state_q;
    logic [NUM_LEDS-1:0]  state_d;
    logic [NUM_LEDS-1:0]  done_d;
    logic [NUM_LEDS-1:0]  led_d;
    logic                 dim_gate_s;

`ifdef LED_BLINK_DIM_EN
    logic [3:0] frame_q;

    // Free-running PWM frame counter for the global dimmer
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            frame_q <= 4'd0;
        end else begin
            frame_q <= frame_q + 4'd1;
        end
    end

    assign dim_gate_s = (frame_q < i_Dim);
`else
    assign dim_gate_s = 1'b1;
`endif

    // Per-channel next state: write beats sync, sync beats counting
    always_comb begin
        for (int ch = 0; ch < NUM_LEDS; ch++) begin
            mode_d[ch]    = mode_q[ch];
            period_d[ch]  = period_q[ch];
            counter_d[ch] = counter_q[ch];
            state_d[ch]   = state_q[ch];
            done_d[ch]    = 1'b0;
            if (i_Wr_En && (i_Wr_Addr == 4'(ch))) begin
                mode_d[ch]    = mode_e'(i_Wr_Mode);
                period_d[ch]  = i_Wr_Period;
                counter_d[ch] = '0;
                state_d[ch]   = (i_Wr_Mode != 2'd0);
            end else if (i_Sync && (mode_q[ch] == MODE_BLINK)) begin
                counter_d[ch] = '0;
                state_d[ch]   = 1'b1;
            end else begin
                case (mode_q[ch])
                    MODE_BLINK: begin
                        if (counter_q[ch] == period_q[ch]) begin
                            counter_d[ch] = '0;
                            state_d[ch]   = ~state_q[ch];
                        end else begin
                            counter_d[ch] = counter_q[ch] + CNT_WIDTH'(1);
                        end
                    end
                    MODE_PULSE: begin
                        if (counter_q[ch] == period_q[ch]) begin
                            counter_d[ch] = '0;
                            state_d[ch]   = 1'b0;
                            mode_d[ch]    = MODE_OFF;
                            done_d[ch]    = 1'b1;
                        end else begin
                            counter_d[ch] = counter_q[ch] + CNT_WIDTH'(1);
                            state_d[ch]   = 1'b1;
                        end
                    end
                    default: begin
                        counter_d[ch] = '0;
                    end
                endcase
            end
        end
        led_d = state_q & {NUM_LEDS{dim_gate_s}};
    end

    // Channel registers and registered outputs
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            for (int ch = 0; ch < NUM_LEDS; ch++) begin
                mode_q[ch]    <= MODE_OFF;
                period_q[ch]  <= CNT_WIDTH'(DEFAULT_PERIOD);
                counter_q[ch] <= '0;
            end
            state_q <= '0;
            o_LED   <= '0;
            o_Done  <= '0;
        end else begin
            for (int ch = 0; ch < NUM_LEDS; ch++) begin
                mode_q[ch]    <= mode_d[ch];
                period_q[ch]  <= period_d[ch];
                counter_q[ch] <= counter_d[ch];
            end
            state_q <= state_d;
            o_LED   <= led_d;
            o_Done  <= done_d;
        end
    end

endmodule

// File: tb/tb_led_blink_multi.sv
// Directed self-checking bench for led_blink_multi (NUM_LEDS=4).
// Inputs change 1 ns after a rising edge; outputs are checked at that same point.
module tb_led_blink_multi;

    logic        i_Clk = 1'b0;
    logic        i_Reset;
    logic        i_Wr_En;
    logic [3:0]  i_Wr_Addr;
    logic [1:0]  i_Wr_Mode;
    logic [23:0] i_Wr_Period;
    logic        i_Sync;
`ifdef LED_BLINK_DIM_EN
    logic [3:0]  i_Dim;
`endif
    logic [3:0]  o_LED;
    logic [3:0]  o_Done;

    int n_chk  = 0;
    int n_fail = 0;

    led_blink_multi #(.NUM_LEDS(4), .CNT_WIDTH(24), .DEFAULT_PERIOD(1250000)) dut (
        .i_Clk       (i_Clk),
        .i_Reset     (i_Reset),
        .i_Wr_En     (i_Wr_En),
        .i_Wr_Addr   (i_Wr_Addr),
        .i_Wr_Mode   (i_Wr_Mode),
        .i_Wr_Period (i_Wr_Period),
        .i_Sync      (i_Sync),
`ifdef LED_BLINK_DIM_EN
        .i_Dim       (i_Dim),
`endif
        .o_LED       (o_LED),
        .o_Done      (o_Done)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [1:0] m, input logic [23:0] p);
        i_Wr_En     = 1'b1;
        i_Wr_Addr   = a;
        i_Wr_Mode   = m;
        i_Wr_Period = p;
        tick();
        i_Wr_En     = 1'b0;
    endtask

    task automatic do_reset();
        i_Reset = 1'b1;
        tick();
        tick();
        i_Reset = 1'b0;
    endtask

    task automatic test_reset();
        i_Reset = 1'b1;
        tick();
        tick();
        n_chk++;
        if (o_LED !== 4'b0000 || o_Done !== 4'b0000) begin
            $display("FAIL reset_held o_LED=%b o_Done=%b expected 0000/0000", o_LED, o_Done);
            n_fail++;
        end
        i_Reset = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            n_chk++;
            if (o_LED !== 4'b0000 || o_Done !== 4'b0000) begin
                $display("FAIL reset_idle k=%0d o_LED=%b o_Done=%b expected 0000/0000", k, o_LED, o_Done);
                n_fail++;
            end
        end
    endtask

    task automatic test_blink();
        logic [3:0] exp;
        do_reset();
        wr(4'd0, 2'd2, 24'd3);
        n_chk++;
        if (o_LED !== 4'b0000) begin
            $display("FAIL blink_latency o_LED=%b expected 0000", o_LED);
            n_fail++;
        end
        for (int k = 1; k <= 24; k++) begin
            tick();
            exp = {3'b000, (((k - 1) / 4) % 2 == 0)};
            n_chk++;
            if (o_LED !== exp || o_Done !== 4'b0000) begin
                $display("FAIL blink k=%0d o_LED=%b o_Done=%b expected %b/0000", k, o_LED, o_Done, exp);
                n_fail++;
            end
        end
    endtask

    task automatic test_pulse();
        logic [3:0] exp_led;
        logic [3:0] exp_done;
        do_reset();
        wr(4'd2, 2'd3, 24'd5);
        for (int k = 1; k <= 14; k++) begin
            tick();
            exp_led  = (k <= 6) ? 4'b0100 : 4'b0000;
            exp_done = (k == 6) ? 4'b0100 : 4'b0000;
            n_chk++;
            if (o_LED !== exp_led || o_Done !== exp_done) begin
                $display("FAIL pulse k=%0d o_LED=%b o_Done=%b expected %b/%b", k, o_LED, o_Done, exp_led, exp_done);
                n_fail++;
            end
        end
    endtask

    task automatic test_sync();
        logic [3:0] exp;
        do_reset();
        wr(4'd0, 2'd2, 24'd9);
        tick();
        tick();
        tick();
        wr(4'd1, 2'd2, 24'd4);
        tick();
        tick();
        i_Sync = 1'b1;
        tick();
        i_Sync = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp = {2'b00, (((k - 1) / 5) % 2 == 0), (((k - 1) / 10) % 2 == 0)};
            n_chk++;
            if (o_LED !== exp) begin
                $display("FAIL sync k=%0d o_LED=%b expected %b", k, o_LED, exp);
                n_fail++;
            end
        end
    endtask

    task automatic test_ignored_and_override();
        do_reset();
        wr(4'd0, 2'd1, 24'd0);
        wr(4'd7, 2'd1, 24'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            n_chk++;
            if (o_LED !== 4'b0001 || o_Done !== 4'b0000) begin
                $display("FAIL bad_addr k=%0d o_LED=%b o_Done=%b expected 0001/0000", k, o_LED, o_Done);
                n_fail++;
            end
        end
        wr(4'd1, 2'd3, 24'd2);
        tick();
        tick();
        wr(4'd1, 2'd1, 24'd0);
        for (int k = 0; k < 10; k++) begin
            n_chk++;
            if (o_LED !== 4'b0011 || o_Done !== 4'b0000) begin
                $display("FAIL override k=%0d o_LED=%b o_Done=%b expected 0011/0000", k, o_LED, o_Done);
                n_fail++;
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_led;
        logic [3:0] exp_done;
        do_reset();
        wr(4'd0, 2'd2, 24'd1);
        wr(4'd1, 2'd3, 24'd0);
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) tick();
            exp_led  = {2'b00, (k == 2), (((k - 1) / 2) % 2 == 0)};
            exp_done = (k == 2) ? 4'b0010 : 4'b0000;
            n_chk++;
            if (o_LED !== exp_led || o_Done !== exp_done) begin
                $display("FAIL back_to_back k=%0d o_LED=%b o_Done=%b expected %b/%b", k, o_LED, o_Done, exp_led, exp_done);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr(4'd2, 2'd3, 24'd5);
        wr(4'd3, 2'd1, 24'd0);
        tick();
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            n_chk++;
            if (o_LED !== 4'b0000 || o_Done !== 4'b0000) begin
                $display("FAIL reset_mid k=%0d o_LED=%b o_Done=%b expected 0000/0000", k, o_LED, o_Done);
                n_fail++;
            end
            tick();
        end
    endtask

`ifdef LED_BLINK_DIM_EN
    task automatic test_dim();
        int highs;
        do_reset();
        i_Dim = 4'd4;
        wr(4'd0, 2'd1, 24'd0);
        tick();
        highs = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (o_LED[0] === 1'b1) highs++;
        end
        n_chk++;
        if (highs !== 4) begin
            $display("FAIL dim4 high_cycles=%0d expected 4", highs);
            n_fail++;
        end
        i_Dim = 4'd0;
        tick();
        for (int k = 0; k < 16; k++) begin
            tick();
            n_chk++;
            if (o_LED !== 4'b0000) begin
                $display("FAIL dim0 k=%0d o_LED=%b expected 0000", k, o_LED);
                n_fail++;
            end
        end
    endtask
`endif

    initial begin
        i_Reset     = 1'b1;
        i_Wr_En     = 1'b0;
        i_Wr_Addr   = 4'd0;
        i_Wr_Mode   = 2'd0;
        i_Wr_Period = 24'd0;
        i_Sync      = 1'b0;
`ifdef LED_BLINK_DIM_EN
        i_Dim       = 4'd0;
        test_reset();
        test_dim();
`else
        test_reset();
        test_blink();
        test_pulse();
        test_sync();
        test_ignored_and_override();
        test_back_to_back();
        test_reset_mid();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/led_blink_multi.md
# led_blink_multi

Parametrised multi-channel LED driver, the successor to the fixed four-LED, fixed-rate blinker. It drives `NUM_LEDS` outputs, each with a run-time programmable mode (off, on, blink, one-shot pulse) and period, loaded through a simple write port. It sits between board-level control logic (status/debug FSMs) and the LED pins. An optional global PWM dimmer can be compiled in.

## Interface
- `NUM_LEDS`, 4: number of LED channels, 1..16.
- `CNT_WIDTH`, 24: width of period and counter per channel.
- `DEFAULT_PERIOD`, 1250000: period loaded into every channel at reset.
- `i_Clk`  in  1  system clock.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_Wr_En`  in  1  write strobe, one channel per cycle.
- `i_Wr_Addr`  in  4  target channel index.
- `i_Wr_Mode`  in  2  0=OFF, 1=ON, 2=BLINK, 3=PULSE.
- `i_Wr_Period`  in  CNT_WIDTH  half-period / pulse length minus one.
- `i_Sync`  in  1  phase-align all BLINK channels.
- `i_Dim`  in  4  global brightness; present only with `LED_BLINK_DIM_EN`.
- `o_LED`  out  NUM_LEDS  LED drive, registered.
- `o_Done`  out  NUM_LEDS  one-cycle strobe when a PULSE completes.

## Operation
- One clock; reset is synchronous and active-high.
- Per channel state: mode (2 b), period (CNT_WIDTH), counter (CNT_WIDTH), LED state (1 b).
- Reset: mode=OFF, period=DEFAULT_PERIOD, counter=0, state=0, `o_LED`=0, `o_Done`=0.
- Write (`i_Wr_En`=1, `i_Wr_Addr` < NUM_LEDS):
  - loads mode and period and clears the counter;
  - sets state to OFF→0, ON→1, BLINK→1, PULSE→1.
  - Writes with `i_Wr_Addr` ≥ NUM_LEDS are ignored, with no side effects.
- OFF / ON: state is held and the counter is frozen at 0.
- BLINK:
  - counter increments each cycle;
  - when counter == period, the state toggles and the counter returns to 0;
  - each level lasts period+1 cycles, so period=0 toggles every cycle.
- PULSE:
  - state=1 and the counter increments;
  - when counter == period: state←0, mode←OFF, counter←0, and `o_Done[ch]`=1 for exactly one cycle;
  - pulse width is period+1 cycles.
- `i_Sync`=1: every BLINK channel sets counter←0 and state←1. Other modes are unaffected.
- Priority: `i_Reset` > write to a channel > `i_Sync` > normal counting.
- A write to a channel in the same cycle its PULSE would complete:
  - the write wins;
  - `o_Done` is not asserted.
- Counter never exceeds the period, so there is no wrap or overflow handling.
- A period rewrite takes effect immediately, because the counter is cleared.

## Timing
- All outputs are registered.
- Write, sync or toggle at edge N → `o_LED` changes at edge N+1.
- PULSE with period P written at edge N:
  - `o_LED`=1 for edges N+1 .. N+P+1, falling at N+P+2;
  - `o_Done` is high for the one cycle after edge N+P+1.
- Reset mid-operation clears all state on the next edge. No partial pulse or `o_Done` is emitted afterwards.
- Throughput: one write per cycle, zero wait states, no back-pressure.

## Configuration
- Macro `LED_BLINK_DIM_EN`.
- Defined:
  - adds `i_Dim` and a 4-bit free-running frame counter (reset 0, wraps 15→0);
  - `o_LED[ch]` = state[ch] AND (frame < `i_Dim`), registered;
  - `i_Dim`=0 blanks all LEDs; `i_Dim`=8 gives a 50 % duty cycle.
  - Mode, timing and `o_Done` are unchanged.
- Undefined:
  - no `i_Dim` port and no frame counter;
  - `o_LED[ch]` = registered state[ch].

## Test plan
- Reset release, no writes → `o_LED`=0 and `o_Done`=0 for 100 cycles.
- Write ch0 BLINK, period=3 → `o_LED[0]` is high for 4 cycles, then low for 4 cycles, repeating; other channels stay 0.
- Write ch2 PULSE, period=5 → `o_LED[2]` is high for exactly 6 cycles; `o_Done[2]` pulses once, 1 cycle wide, aligned with the last high cycle; ch2 then reads OFF.
- ch0 BLINK period=9 and ch1 BLINK period=4, written at different times, then `i_Sync` → both go high on the next cycle. ch1 then toggles every 5 cycles and ch0 every 10 cycles, in phase.
- Write to address 7 with NUM_LEDS=4 → no output change. Write ch1 PULSE with period=2, then rewrite ch1 ON on the cycle the pulse would end → `o_LED[1]` stays 1 and `o_Done[1]` is never asserted.
- `LED_BLINK_DIM_EN` defined, ch0 ON, `i_Dim`=4 → `o_LED[0]` is high for 4 of every 16 cycles. With `i_Dim`=0 it is always low.
